dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 20 ++
 rtl/dm_arbiter_if.sv | 41 ++++
 rtl/dm_arbiter_rr_hold_pick.sv | 40 ++++
 rtl/dm_arbiter.sv | 111 +++++++++++
 tb/tb_dm_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// ============================================================================
// Module   : dm_arbiter_pkg
// Purpose  : Shared port indices, hold-counter width and helpers for dm_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dm_arbiter_pkg;

    localparam logic PORT0  = 1'b0;
    localparam logic PORT1  = 1'b1;
    localparam int   HOLD_W = 4;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_if.sv
// ============================================================================
// Module   : dm_arbiter_if
// Purpose  : Two requester ports plus the shared memory port of dm_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          r0_req,    r1_req;
    logic          r0_we,     r1_we;
    logic [AW-1:0] r0_addr,   r1_addr;
    logic [DW-1:0] r0_wdata,  r1_wdata;
    logic [31:0]   r0_pc4,    r1_pc4;
    logic          r0_gnt,    r1_gnt;
    logic          r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata,  r1_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [31:0]   m_pc4;
    logic          m_we;
    logic [DW-1:0] m_dout;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
               r0_wdata, r1_wdata, r0_pc4, r1_pc4, m_dout,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               m_addr, m_din, m_pc4, m_we
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
               r0_wdata, r1_wdata, r0_pc4, r1_pc4, m_dout,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
               m_addr, m_din, m_pc4, m_we
    );
endinterface

`default_nettype wire

// File: rtl/dm_arbiter_rr_hold_pick.sv
// ============================================================================
// Module   : rr_hold_pick
// Purpose  : One-hot grant pick between two requesters with bounded hold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_hold_pick
    import dm_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic [1:0]        req,
    input  logic              last,
    input  logic [HOLD_W-1:0] hold_cnt,
    output logic [1:0]        gnt
);

    logic w_stay;
    logic w_pick;

    always_comb begin
        gnt    = 2'b00;
        w_stay = (hold_cnt != '0) && (hold_cnt < HOLD_W'(MAX_HOLD));
        w_pick = PORT0;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                // Stay with the previous winner until its run reaches MAX_HOLD.
                w_pick = w_stay ? last : other_port(last);
                gnt    = (w_pick == PORT1) ? 2'b10 : 2'b01;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Zero-latency two-port arbiter onto a single combinational memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave bus
);

    logic [1:0]        w_pick_gnt;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_port;
    logic              w_rd0;
    logic              w_rd1;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_din;
    logic [31:0]       w_pc4;
    logic              w_we;

    logic              r_last;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DW-1:0]     r_rdata0;
    logic [DW-1:0]     r_rdata1;

    rr_hold_pick #(
        .MAX_HOLD (MAX_HOLD)
    ) u_pick (
        .req      ({bus.r1_req, bus.r0_req}),
        .last     (r_last),
        .hold_cnt (r_hold_cnt),
        .gnt      (w_pick_gnt)
    );

    // Reset masks the grant so nothing reaches memory while it is asserted.
    assign w_gnt  = reset ? 2'b00 : w_pick_gnt;
    assign w_any  = |w_gnt;
    assign w_port = w_gnt[1] ? PORT1 : PORT0;
    assign w_rd0  = w_gnt[0] & ~bus.r0_we;
    assign w_rd1  = w_gnt[1] & ~bus.r1_we;

    always_comb begin
        w_addr = '0;
        w_din  = '0;
        w_pc4  = '0;
        w_we   = 1'b0;
        if (w_gnt[0]) begin
            w_addr = bus.r0_addr;
            w_din  = bus.r0_wdata;
            w_pc4  = bus.r0_pc4;
            w_we   = bus.r0_we;
        end else if (w_gnt[1]) begin
            w_addr = bus.r1_addr;
            w_din  = bus.r1_wdata;
            w_pc4  = bus.r1_pc4;
            w_we   = bus.r1_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= PORT1;
            r_hold_cnt <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0) r_rdata0 <= bus.m_dout;
            if (w_rd1) r_rdata1 <= bus.m_dout;
            if (w_any) begin
                r_last <= w_port;
                if (w_port == r_last)
                    r_hold_cnt <= (r_hold_cnt >= HOLD_W'(MAX_HOLD)) ?
                                  HOLD_W'(MAX_HOLD) : r_hold_cnt + HOLD_W'(1);
                else
                    r_hold_cnt <= HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign bus.r0_gnt    = w_gnt[0];
    assign bus.r1_gnt    = w_gnt[1];
    assign bus.r0_rvalid = r_rvalid0;
    assign bus.r1_rvalid = r_rvalid1;
    assign bus.r0_rdata  = r_rdata0;
    assign bus.r1_rdata  = r_rdata1;
    assign bus.m_addr    = w_addr;
    assign bus.m_din     = w_din;
    assign bus.m_pc4     = w_pc4;
    assign bus.m_we      = w_we;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Directed self-checking bench for dm_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [31:0] mem [0:63];

    dm_arbiter_if #(.AW(32), .DW(32)) bus ();

    dm_arbiter #(
        .AW       (32),
        .DW       (32),
        .MAX_HOLD (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.m_dout = mem[bus.m_addr[7:2]];
    always @(posedge clk) if (bus.m_we) mem[bus.m_addr[7:2]] <= bus.m_din;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc4);
        bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr;
        bus.r0_wdata = wdata; bus.r0_pc4 = pc4;
    endtask

    task automatic set_r1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc4);
        bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr;
        bus.r1_wdata = wdata; bus.r1_pc4 = pc4;
    endtask

    int exp_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset with both ports requesting: nothing may be granted.
        reset = 1'b1;
        set_r0(1'b1, 1'b1, 32'h10, 32'h1111_1111, 32'h100);
        set_r1(1'b1, 1'b0, 32'h14, 32'h0, 32'h200);
        #1;
        check("rst_gnt0", bus.r0_gnt, 1'b0);
        check("rst_gnt1", bus.r1_gnt, 1'b0);
        check("rst_m_we", bus.m_we, 1'b0);
        step();
        check("rst_rvalid0", bus.r0_rvalid, 1'b0);
        check("rst_rvalid1", bus.r1_rvalid, 1'b0);
        check("rst_rdata1", bus.r1_rdata, 32'h0);
        check("rst_hold", dut.r_hold_cnt, 4'd0);
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_r1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        step();

        // r0 writes DEADBEEF to 0x10.
        set_r0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h104);
        #1;
        check("wr_gnt0", bus.r0_gnt, 1'b1);
        check("wr_gnt1", bus.r1_gnt, 1'b0);
        check("wr_m_we", bus.m_we, 1'b1);
        check("wr_m_addr", bus.m_addr, 32'h10);
        check("wr_m_din", bus.m_din, 32'hDEAD_BEEF);
        check("wr_m_pc4", bus.m_pc4, 32'h104);
        step();
        check("wr_no_rvalid0", bus.r0_rvalid, 1'b0);

        // r1 reads 0x10 back.
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_r1(1'b1, 1'b0, 32'h10, 32'h5555_5555, 32'h208);
        #1;
        check("rd_gnt1", bus.r1_gnt, 1'b1);
        check("rd_gnt0", bus.r0_gnt, 1'b0);
        check("rd_m_we", bus.m_we, 1'b0);
        check("rd_m_addr", bus.m_addr, 32'h10);
        check("rd_m_pc4", bus.m_pc4, 32'h208);
        step();
        check("rd_rvalid1", bus.r1_rvalid, 1'b1);
        check("rd_rdata1", bus.r1_rdata, 32'hDEAD_BEEF);
        check("rd_rvalid0", bus.r0_rvalid, 1'b0);

        // Three idle cycles: memory port quiet, hold count cleared, rdata held.
        set_r1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_m_we", bus.m_we, 1'b0);
            check("idle_m_addr", bus.m_addr, 32'h0);
            check("idle_m_din", bus.m_din, 32'h0);
            step();
            check("idle_hold", dut.r_hold_cnt, 4'd0);
            check("idle_rvalid1", bus.r1_rvalid, 1'b0);
            check("idle_rdata1", bus.r1_rdata, 32'hDEAD_BEEF);
        end

        // Single r0 read leaves last = 0, then one idle cycle.
        set_r0(1'b1, 1'b0, 32'h10, 32'h0, 32'h300);
        #1;
        check("r0rd_gnt0", bus.r0_gnt, 1'b1);
        step();
        check("r0rd_rvalid0", bus.r0_rvalid, 1'b1);
        check("r0rd_rdata0", bus.r0_rdata, 32'hDEAD_BEEF);
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        check("r0rd_rvalid0_drop", bus.r0_rvalid, 1'b0);

        // Contention after idle with last = 0: port 1 first, then keeps it.
        set_r0(1'b1, 1'b0, 32'h20, 32'h0, 32'h400);
        set_r1(1'b1, 1'b0, 32'h10, 32'h0, 32'h500);
        #1;
        check("cont_gnt1", bus.r1_gnt, 1'b1);
        check("cont_gnt0", bus.r0_gnt, 1'b0);
        check("cont_m_addr", bus.m_addr, 32'h10);
        step();
        check("cont2_gnt1", bus.r1_gnt, 1'b1);
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_r1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();

        // Continuous contention from reset: 0,0,0,0,1,1,1,1,0.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_r0(1'b1, 1'b0, 32'h20, 32'h0, 32'h0);
        set_r1(1'b1, 1'b0, 32'h24, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("seq%0d_gnt0", i), bus.r0_gnt, (exp_seq[i] == 0));
            check($sformatf("seq%0d_gnt1", i), bus.r1_gnt, (exp_seq[i] == 1));
            step();
        end

        // Grant r1 alone (last = 1, hold = 1), then reset during an r0 read grant.
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #1;
        check("pre_gnt1", bus.r1_gnt, 1'b1);
        step();
        set_r1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_r0(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        #1;
        check("mid_gnt0", bus.r0_gnt, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_gnt0", bus.r0_gnt, 1'b0);
        check("mid_rst_m_we", bus.m_we, 1'b0);
        check("mid_rst_rvalid1", bus.r1_rvalid, 1'b0);
        step();
        check("mid_rst_rvalid0", bus.r0_rvalid, 1'b0);
        check("mid_rst_gnt0_b", bus.r0_gnt, 1'b0);
        reset = 1'b0;
        set_r1(1'b1, 1'b0, 32'h14, 32'h0, 32'h0);
        #1;
        check("post_rst_gnt0", bus.r0_gnt, 1'b1);
        check("post_rst_gnt1", bus.r1_gnt, 1'b0);
        step();
        check("post_rst_rvalid0", bus.r0_rvalid, 1'b1);
        set_r0(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_r1(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
